mem_port_arbiter: RTL and testbench

Sequential arbiter sharing one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the pipelined MIPS core. Grants one requester at a time, sequences the memory's fixed access latency with a wait-state counter, returns read data with a one-cycle ready pulse, and drives stall requests that the pipeline control ORs into its PC/IF_ID write-enable logic.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Optional ARB_FAIRNESS_EN: alternate grants when both sides request together.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              ram_en_nx, ram_we_nx;
  logic [ADDR_W-1:0] ram_addr_nx;
  logic [DATA_W-1:0] ram_wdata_nx;
  logic              if_ready_nx, mem_ready_nx;
  logic [DATA_W-1:0] if_rdata_nx, mem_rdata_nx;
  logic              data_req;
  logic              grant_data;

  assign data_req = mem_read | mem_write;

`ifdef ARB_FAIRNESS_EN
  logic last_data, last_data_nx;

  // Yield to fetch once after a data grant if fetch is also waiting.
  assign grant_data = data_req && !(if_req && last_data);
`else
  assign grant_data = data_req;
`endif

  assign stall_if  = if_req && !if_ready;
  assign stall_mem = data_req && !mem_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    ram_en_nx    = ram_en;
    ram_we_nx    = ram_we;
    ram_addr_nx  = ram_addr;
    ram_wdata_nx = ram_wdata;
    if_ready_nx  = 1'b0;
    mem_ready_nx = 1'b0;
    if_rdata_nx  = if_rdata;
    mem_rdata_nx = mem_rdata;
`ifdef ARB_FAIRNESS_EN
    last_data_nx = last_data;
`endif
    unique case (state)
      IDLE: begin
        if (grant_data) begin
          state_nx     = BUSY_D;
          cnt_nx       = CNT_W'(MEM_LAT - 1);
          ram_en_nx    = 1'b1;
          ram_we_nx    = mem_write;
          ram_addr_nx  = mem_addr;
          ram_wdata_nx = mem_wdata;
`ifdef ARB_FAIRNESS_EN
          last_data_nx = 1'b1;
`endif
        end else if (if_req) begin
          state_nx     = BUSY_IF;
          cnt_nx       = CNT_W'(MEM_LAT - 1);
          ram_en_nx    = 1'b1;
          ram_we_nx    = 1'b0;
          ram_addr_nx  = if_addr;
`ifdef ARB_FAIRNESS_EN
          last_data_nx = 1'b0;
`endif
        end
      end
      BUSY_IF, BUSY_D: begin
        if (cnt == '0) begin
          state_nx  = RESP;
          ram_en_nx = 1'b0;
          ram_we_nx = 1'b0;
          if (state == BUSY_IF) begin
            if_rdata_nx = ram_rdata;
            if_ready_nx = 1'b1;
          end else begin
            if (!ram_we) mem_rdata_nx = ram_rdata;
            mem_ready_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
`ifdef ARB_FAIRNESS_EN
      last_data <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ram_en    <= ram_en_nx;
      ram_we    <= ram_we_nx;
      ram_addr  <= ram_addr_nx;
      ram_wdata <= ram_wdata_nx;
      if_ready  <= if_ready_nx;
      mem_ready <= mem_ready_nx;
      if_rdata  <= if_rdata_nx;
      mem_rdata <= mem_rdata_nx;
`ifdef ARB_FAIRNESS_EN
      last_data <= last_data_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_read, mem_write;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ready, mem_ready, ram_en, ram_we, stall_if, stall_mem;

  logic        l1_mem_read, l1_mem_write;
  logic [31:0] l1_mem_addr, l1_mem_wdata;
  logic [31:0] l1_if_rdata, l1_mem_rdata, l1_ram_addr, l1_ram_wdata;
  logic        l1_if_ready, l1_mem_ready, l1_ram_en, l1_ram_we, l1_stall_if, l1_stall_mem;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
    .mem_read(l1_mem_read), .mem_write(l1_mem_write), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .mem_ready(l1_mem_ready),
    .ram_en(l1_ram_en), .ram_we(l1_ram_we), .ram_addr(l1_ram_addr), .ram_wdata(l1_ram_wdata),
    .ram_rdata(32'hFFFF_FFFF), .stall_if(l1_stall_if), .stall_mem(l1_stall_mem)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++;
    if ({ram_en, ram_we, if_ready, mem_ready} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {ram_en, ram_we, if_ready, mem_ready});
    end
    total++;
    if ({ram_addr, ram_wdata, if_rdata, mem_rdata} !== 128'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {ram_addr, ram_wdata, if_rdata, mem_rdata});
    end
    total++;
    if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin
      bad++; $display("FAIL reset_stall got=%b%b exp=10", stall_if, stall_mem);
    end
    if_req = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      if_req    = (c <= 3);
      if_addr   = 32'h40;
      ram_rdata = (c == 2) ? 32'h8C22_0004 : 32'h1111_1111;
      @(negedge clk);
      total++;
      if (ram_en !== (c == 1 || c == 2) || ram_we !== 1'b0) begin
        bad++; $display("FAIL fetch_en c=%0d got=%b%b exp=%b0", c, ram_en, ram_we, (c == 1 || c == 2));
      end
      total++;
      if (if_ready !== (c == 3) || mem_ready !== 1'b0) begin
        bad++; $display("FAIL fetch_ready c=%0d got=%b%b exp=%b0", c, if_ready, mem_ready, (c == 3));
      end
      total++;
      if (stall_if !== (c <= 2)) begin
        bad++; $display("FAIL fetch_stall c=%0d got=%b exp=%b", c, stall_if, (c <= 2));
      end
      if (c == 1 || c == 2) begin
        total++;
        if (ram_addr !== 32'h40) begin
          bad++; $display("FAIL fetch_addr c=%0d got=%h exp=40", c, ram_addr);
        end
      end
      if (c >= 3) begin
        total++;
        if (if_rdata !== 32'h8C22_0004) begin
          bad++; $display("FAIL fetch_rdata c=%0d got=%h exp=8c220004", c, if_rdata);
        end
      end
    end
  endtask

  task automatic test_load();
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      mem_read  = (c <= 3);
      mem_addr  = 32'h80;
      ram_rdata = (c == 2) ? 32'hCAFE_F00D : 32'h2222_2222;
      @(negedge clk);
      total++;
      if (ram_en !== (c == 1 || c == 2) || ram_we !== 1'b0) begin
        bad++; $display("FAIL load_en c=%0d got=%b%b exp=%b0", c, ram_en, ram_we, (c == 1 || c == 2));
      end
      total++;
      if (mem_ready !== (c == 3) || stall_mem !== (c <= 2)) begin
        bad++; $display("FAIL load_ready c=%0d got=%b%b exp=%b%b", c, mem_ready, stall_mem, (c == 3), (c <= 2));
      end
      if (c >= 3) begin
        total++;
        if (mem_rdata !== 32'hCAFE_F00D) begin
          bad++; $display("FAIL load_rdata c=%0d got=%h exp=cafef00d", c, mem_rdata);
        end
      end
    end
  endtask

  task automatic test_store();
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      mem_write = (c <= 3);
      mem_addr  = 32'h100;
      mem_wdata = 32'hDEAD_BEEF;
      ram_rdata = 32'h5555_5555;
      @(negedge clk);
      total++;
      if (ram_en !== (c == 1 || c == 2) || ram_we !== (c == 1 || c == 2)) begin
        bad++; $display("FAIL store_en c=%0d got=%b%b exp=%b%b", c, ram_en, ram_we, (c == 1 || c == 2), (c == 1 || c == 2));
      end
      if (c == 1 || c == 2) begin
        total++;
        if (ram_addr !== 32'h100 || ram_wdata !== 32'hDEAD_BEEF) begin
          bad++; $display("FAIL store_bus c=%0d got=%h/%h exp=100/deadbeef", c, ram_addr, ram_wdata);
        end
      end
      total++;
      if (mem_ready !== (c == 3) || if_ready !== 1'b0) begin
        bad++; $display("FAIL store_ready c=%0d got=%b%b exp=%b0", c, mem_ready, if_ready, (c == 3));
      end
      total++;
      if (mem_rdata !== 32'hCAFE_F00D) begin
        bad++; $display("FAIL store_rdata c=%0d got=%h exp=cafef00d", c, mem_rdata);
      end
    end
  endtask

  task automatic test_contention();
    logic exp_mr, exp_ir;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      next_cycle();
      if_req    = (c <= 11);
      mem_read  = (c <= 11);
      if_addr   = 32'h400;
      mem_addr  = 32'h800;
      ram_rdata = 32'hA000 + 32'(c);
      @(negedge clk);
      exp_mr = (c == 3 || c == 11 || (!FAIR && c == 7));
      exp_ir = (FAIR && c == 7);
      total++;
      if (mem_ready !== exp_mr || if_ready !== exp_ir) begin
        bad++; $display("FAIL contend_ready c=%0d got=%b%b exp=%b%b", c, mem_ready, if_ready, exp_mr, exp_ir);
      end
      total++;
      if (ram_en !== (c % 4 == 1 || c % 4 == 2) || ram_we !== 1'b0) begin
        bad++; $display("FAIL contend_en c=%0d got=%b%b exp=%b0", c, ram_en, ram_we, (c % 4 == 1 || c % 4 == 2));
      end
      if (c == 5) begin
        total++;
        if (ram_addr !== (FAIR ? 32'h400 : 32'h800)) begin
          bad++; $display("FAIL contend_addr c=%0d got=%h exp=%h", c, ram_addr, (FAIR ? 32'h400 : 32'h800));
        end
      end
      if (exp_mr) begin
        total++;
        if (mem_rdata !== 32'hA000 + 32'(c - 1)) begin
          bad++; $display("FAIL contend_mrdata c=%0d got=%h exp=%h", c, mem_rdata, 32'hA000 + 32'(c - 1));
        end
      end
      if (exp_ir) begin
        total++;
        if (if_rdata !== 32'hA000 + 32'(c - 1)) begin
          bad++; $display("FAIL contend_irdata c=%0d got=%h exp=%h", c, if_rdata, 32'hA000 + 32'(c - 1));
        end
      end
    end
  endtask

  task automatic test_addr_hold();
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      mem_read  = (c <= 2);
      mem_write = (c == 1 || c == 2);
      mem_addr  = (c == 0) ? 32'h100 : 32'h200;
      ram_rdata = (c == 2) ? 32'h0BAD_CAFE : 32'h3333_3333;
      @(negedge clk);
      if (c == 1 || c == 2) begin
        total++;
        if (ram_addr !== 32'h100 || ram_we !== 1'b0 || ram_en !== 1'b1) begin
          bad++; $display("FAIL hold_bus c=%0d got=%h/%b%b exp=100/10", c, ram_addr, ram_en, ram_we);
        end
      end
      if (c == 3) begin
        total++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h0BAD_CAFE) begin
          bad++; $display("FAIL hold_resp got=%b/%h exp=1/0badcafe", mem_ready, mem_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 7; c++) begin
      next_cycle();
      mem_read  = (c <= 5);
      mem_addr  = 32'h300;
      rst       = (c == 2);
      ram_rdata = 32'h9000 + 32'(c);
      @(negedge clk);
      total++;
      if (ram_en !== (c == 1 || c == 2 || c == 4 || c == 5)) begin
        bad++; $display("FAIL rstmid_en c=%0d got=%b exp=%b", c, ram_en, (c == 1 || c == 2 || c == 4 || c == 5));
      end
      total++;
      if (mem_ready !== (c == 6)) begin
        bad++; $display("FAIL rstmid_ready c=%0d got=%b exp=%b", c, mem_ready, (c == 6));
      end
      if (c == 3) begin
        total++;
        if (ram_addr !== 32'h0 || mem_rdata !== 32'h0) begin
          bad++; $display("FAIL rstmid_clear got=%h/%h exp=0/0", ram_addr, mem_rdata);
        end
      end
      if (c == 6) begin
        total++;
        if (mem_rdata !== 32'h9005) begin
          bad++; $display("FAIL rstmid_rdata got=%h exp=9005", mem_rdata);
        end
      end
    end
  endtask

  task automatic test_lat1_both();
    for (int c = 0; c <= 3; c++) begin
      next_cycle();
      l1_mem_read  = (c <= 1);
      l1_mem_write = (c <= 1);
      l1_mem_addr  = 32'h44;
      l1_mem_wdata = 32'h1234_5678;
      @(negedge clk);
      total++;
      if (l1_ram_en !== (c == 1) || l1_ram_we !== (c == 1)) begin
        bad++; $display("FAIL lat1_en c=%0d got=%b%b exp=%b%b", c, l1_ram_en, l1_ram_we, (c == 1), (c == 1));
      end
      if (c == 1) begin
        total++;
        if (l1_ram_addr !== 32'h44 || l1_ram_wdata !== 32'h1234_5678) begin
          bad++; $display("FAIL lat1_bus got=%h/%h exp=44/12345678", l1_ram_addr, l1_ram_wdata);
        end
      end
      total++;
      if (l1_mem_ready !== (c == 2) || l1_mem_rdata !== 32'h0) begin
        bad++; $display("FAIL lat1_ready c=%0d got=%b/%h exp=%b/0", c, l1_mem_ready, l1_mem_rdata, (c == 2));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
    l1_mem_read = 1'b0; l1_mem_write = 1'b0; l1_mem_addr = '0; l1_mem_wdata = '0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_contention();
    test_addr_hold();
    test_reset_mid();
    test_lat1_both();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
